// File: rtl/mips_pkg.sv
// Shared encodings for the fetch-side PC logic: FSM states, redirect kinds
// (ordered so a larger value outranks a smaller one) and default vectors.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    R_NONE = 3'd0,
    R_BR   = 3'd1,
    R_J    = 3'd2,
    R_JR   = 3'd3,
    R_EXC  = 3'd4
  } redir_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int unsigned DEF_INC          = 4;

  function automatic logic outranks(input redir_e a, input redir_e b);
    return a > b;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Fetch handshake between the PC unit (master) and the instruction memory (slave).
interface pc_unit_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] Output;
  logic             ImemValid;
  logic             ImemReady;

  modport master (output Output, output ImemValid, input ImemReady);
  modport slave  (input Output, input ImemValid, output ImemReady);

endinterface

// File: rtl/pc_next_sel.sv
// Redirect target computation and priority select. Reports the winning new
// redirect separately so the caller can pend it when fetch cannot advance.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic             en,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic             Jump,
  input  logic [25:0]      JumpTarget,
  input  logic             JumpReg,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Exception,
  input  redir_e           pend_kind,
  input  logic [WIDTH-1:0] pend_target,
  output redir_e           new_kind,
  output logic [WIDTH-1:0] new_target,
  output logic [WIDTH-1:0] next_pc,
  output logic             jr_misalign
);

  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic             jr_bad;

  assign br_tgt = pc_plus4 + (BranchOffset << 2);
  assign j_tgt  = {pc_plus4[WIDTH-1:28], JumpTarget, 2'b00};
  assign jr_bad = (RegTarget[1:0] != 2'b00);

  // A misaligned JR is turned into an exception here so it shares the EXC slot.
  always_comb begin
    new_kind    = R_NONE;
    new_target  = pc_plus4;
    jr_misalign = 1'b0;
    if (en) begin
      if (Exception) begin
        new_kind   = R_EXC;
        new_target = EXC_VECTOR;
      end else if (JumpReg && jr_bad) begin
        new_kind    = R_EXC;
        new_target  = EXC_VECTOR;
        jr_misalign = 1'b1;
      end else if (JumpReg) begin
        new_kind   = R_JR;
        new_target = RegTarget;
      end else if (Jump) begin
        new_kind   = R_J;
        new_target = j_tgt;
      end else if (BranchTaken) begin
        new_kind   = R_BR;
        new_target = br_tgt;
      end
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    if (new_kind != R_NONE) begin
      next_pc = new_target;
    end else if (pend_kind != R_NONE) begin
      next_pc = pend_target;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: run/halt FSM, pending-redirect slot, EPC capture and
// the valid/ready request towards imem.
//
// state  | meaning
// S_IDLE | out of reset, no fetch requested
// S_RUN  | fetching, PC advances on accepted requests
// S_HALT | halted, PC frozen, pending redirect retained
module pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned      INC          = DEF_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic             Jump,
  input  logic [25:0]      JumpTarget,
  input  logic             JumpReg,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic             Exception,
  pc_unit_if.master        imem,
  output logic [WIDTH-1:0] PcPlus4,
  output logic [WIDTH-1:0] Epc,
  output logic             Misaligned,
  output logic             Running
);

  state_e           state;
  logic [WIDTH-1:0] pc;
  redir_e           pend_kind;
  logic [WIDTH-1:0] pend_target;
  logic             running_q;
  logic             misalign_q;
  logic [WIDTH-1:0] epc_q;

  redir_e           new_kind;
  logic [WIDTH-1:0] new_target;
  logic [WIDTH-1:0] next_pc;
  logic             jr_misalign;
  logic             advance;
  logic             exc_accept;

  assign PcPlus4        = pc + WIDTH'(INC);
  assign imem.Output    = pc;
  assign imem.ImemValid = running_q;
  assign Running        = running_q;
  assign Misaligned     = misalign_q;
  assign Epc            = epc_q;

  assign advance = running_q & imem.ImemReady & ~Stall & ~Halt;

  // An exception already sitting in pending blocks a second capture of Epc.
  assign exc_accept = (new_kind == R_EXC) && (advance || (pend_kind != R_EXC));

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .pc_plus4     (PcPlus4),
    .en           (running_q),
    .BranchTaken  (BranchTaken),
    .BranchOffset (BranchOffset),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .JumpReg      (JumpReg),
    .RegTarget    (RegTarget),
    .Exception    (Exception),
    .pend_kind    (pend_kind),
    .pend_target  (pend_target),
    .new_kind     (new_kind),
    .new_target   (new_target),
    .next_pc      (next_pc),
    .jr_misalign  (jr_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      running_q   <= 1'b0;
      pc          <= RESET_VECTOR;
      pend_kind   <= R_NONE;
      pend_target <= '0;
      epc_q       <= '0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;

      case (state)
        S_IDLE, S_HALT: begin
          if (Start && !Halt) begin
            state     <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (Halt) begin
            state     <= S_HALT;
            running_q <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase

      if (advance) begin
        pc        <= next_pc;
        pend_kind <= R_NONE;
      end else if (outranks(new_kind, pend_kind)) begin
        pend_kind   <= new_kind;
        pend_target <= new_target;
      end

      if (exc_accept) begin
        epc_q      <= pc;
        misalign_q <= jr_misalign;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential fetch, redirects, stall/pending,
// exceptions, misaligned JR, halt/resume, wrap and async reset.
module tb_pc_unit;
  localparam int WIDTH = 32;
  localparam logic [31:0] EXC = 32'h8000_0180;

  logic              clk;
  logic              rst;
  logic              Start, Halt, Stall;
  logic              BranchTaken, Jump, JumpReg, Exception;
  logic [WIDTH-1:0]  BranchOffset, RegTarget;
  logic [25:0]       JumpTarget;
  logic [WIDTH-1:0]  PcPlus4, Epc;
  logic              Misaligned, Running;

  int n_chk;
  int n_pass;

  pc_unit_if #(.WIDTH(WIDTH)) imem ();

  pc_unit #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .Start        (Start),
    .Halt         (Halt),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchOffset (BranchOffset),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .JumpReg      (JumpReg),
    .RegTarget    (RegTarget),
    .Exception    (Exception),
    .imem         (imem.master),
    .PcPlus4      (PcPlus4),
    .Epc          (Epc),
    .Misaligned   (Misaligned),
    .Running      (Running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    Start = 0; Halt = 0; Stall = 0;
    BranchTaken = 0; Jump = 0; JumpReg = 0; Exception = 0;
    BranchOffset = '0; RegTarget = '0; JumpTarget = '0;
    imem.ImemReady = 1'b1;
    step(); step();
    chk("rst_pc", imem.Output, 32'h0);
    chk("rst_epc", Epc, 32'h0);
    chk("rst_run", {31'b0, Running}, 32'h0);
    chk("rst_valid", {31'b0, imem.ImemValid}, 32'h0);
    chk("rst_mis", {31'b0, Misaligned}, 32'h0);
    rst = 1'b0;
    step();
    chk("idle_hold", imem.Output, 32'h0);

    Start = 1; step(); Start = 0;
    chk("start_run", {31'b0, Running}, 32'h1);
    chk("start_valid", {31'b0, imem.ImemValid}, 32'h1);
    chk("start_pc", imem.Output, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", imem.Output, 32'(4 * i));
    end

    BranchTaken = 1; BranchOffset = 32'hFFFF_FFFE; step(); BranchTaken = 0;
    chk("branch_back", imem.Output, 32'h0C);
    for (int i = 0; i < 5; i++) step();
    chk("seq_to_20", imem.Output, 32'h20);
    Jump = 1; JumpTarget = 26'h40; step(); Jump = 0;
    chk("jump", imem.Output, 32'h100);
    JumpReg = 1; RegTarget = 32'h40; step(); JumpReg = 0;
    chk("jr", imem.Output, 32'h40);
    chk("jr_aligned", {31'b0, Misaligned}, 32'h0);

    Stall = 1; Jump = 1; JumpTarget = 26'h40; step(); Jump = 0;
    chk("stall1", imem.Output, 32'h40);
    chk("stall_valid", {31'b0, imem.ImemValid}, 32'h1);
    step(); chk("stall2", imem.Output, 32'h40);
    step(); chk("stall3", imem.Output, 32'h40);
    Stall = 0; step();
    chk("pend_jump", imem.Output, 32'h100);
    step(); chk("pend_clear", imem.Output, 32'h104);

    JumpReg = 1; RegTarget = 32'h40; step(); JumpReg = 0;
    Stall = 1; Jump = 1; JumpTarget = 26'h3; step(); Jump = 0;
    chk("pj_hold", imem.Output, 32'h40);
    Exception = 1; step(); Exception = 0;
    chk("pe_hold", imem.Output, 32'h40);
    Stall = 0; step();
    chk("pend_exc", imem.Output, EXC);
    chk("pend_epc", Epc, 32'h40);
    step(); chk("after_exc", imem.Output, EXC + 32'h4);

    JumpReg = 1; RegTarget = 32'h102; step(); JumpReg = 0;
    chk("mis_pc", imem.Output, EXC);
    chk("mis_pulse", {31'b0, Misaligned}, 32'h1);
    chk("mis_epc", Epc, EXC + 32'h4);
    step();
    chk("mis_drop", {31'b0, Misaligned}, 32'h0);
    chk("mis_epc_keep", Epc, EXC + 32'h4);

    JumpReg = 1; RegTarget = 32'h8; step(); JumpReg = 0;
    Halt = 1; step(); Halt = 0;
    chk("halt_pc", imem.Output, 32'h8);
    chk("halt_run", {31'b0, Running}, 32'h0);
    chk("halt_valid", {31'b0, imem.ImemValid}, 32'h0);
    step(); chk("halt_frozen", imem.Output, 32'h8);
    Start = 1; step(); Start = 0;
    chk("resume_run", {31'b0, Running}, 32'h1);
    chk("resume_pc", imem.Output, 32'h8);
    step(); chk("resume_adv", imem.Output, 32'hC);

    Halt = 1; Jump = 1; JumpTarget = 26'h10; step(); Halt = 0; Jump = 0;
    chk("halt_redir_pc", imem.Output, 32'hC);
    Start = 1; step(); Start = 0;
    chk("halt_redir_hold", imem.Output, 32'hC);
    step(); chk("halt_redir_take", imem.Output, 32'h40);
    step(); chk("halt_redir_seq", imem.Output, 32'h44);

    JumpReg = 1; RegTarget = 32'hFFFF_FFFC; step(); JumpReg = 0;
    chk("wrap_top", imem.Output, 32'hFFFF_FFFC);
    chk("wrap_plus4", PcPlus4, 32'h0);
    step(); chk("wrap_zero", imem.Output, 32'h0);
    chk("wrap_epc", Epc, EXC + 32'h4);

    Stall = 1; Jump = 1; JumpTarget = 26'h100; step(); Jump = 0;
    #3 rst = 1'b1;
    #1;
    chk("arst_pc", imem.Output, 32'h0);
    chk("arst_run", {31'b0, Running}, 32'h0);
    chk("arst_epc", Epc, 32'h0);
    #2 rst = 1'b0;
    Stall = 0;
    Start = 1; step(); Start = 0;
    chk("arst_restart", imem.Output, 32'h0);
    step(); chk("arst_no_pend", imem.Output, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
